// File: rtl/lemming_pkg.sv
// rtl/lemming_pkg.sv - shared Lemmings2 walker encodings and world constants
package lemming_pkg;

    typedef enum logic [1:0] {
        WALK_LEFT  = 2'b00,
        WALK_RIGHT = 2'b01,
        FALL_LEFT  = 2'b10,
        FALL_RIGHT = 2'b11
    } walker_state_e;

    localparam int FALL_COUNT_W = 8;

    // Counter width for a modulus n; a modulus of 1 still needs one bit of storage.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lemming_mod_counter.sv
// rtl/lemming_mod_counter.sv - mod-N counter with enable/clear and terminal pulse
module lemming_mod_counter
    import lemming_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int             W    = cnt_width(N);
    localparam logic [W-1:0]   LAST = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Pulses on the enabled cycle that wraps the count back to zero.
    assign tc_o = en_i & ~clr_i & (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lemming_world.sv
// rtl/lemming_world.sv - 1-D track environment closing the loop around a Lemmings2 walker
module lemming_world
    import lemming_pkg::*;
#(
    parameter int                    TRACK_LEN   = 16,
    parameter int                    POS_W       = 4,
    parameter int                    START_POS   = 8,
    parameter logic [TRACK_LEN-1:0]  HOLE_MAP    = 16'h0020,
    parameter int                    STEP_DIV    = 2,
    parameter int                    FALL_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     walk_left,
    input  logic                     walk_right,
    input  logic                     aaah,
    output logic                     bump_left,
    output logic                     bump_right,
    output logic                     ground,
    output logic [POS_W-1:0]         pos,
    output logic [FALL_COUNT_W-1:0]  fall_count,
    output logic                     protocol_err
);

    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(TRACK_LEN - 1);
    localparam logic [POS_W-1:0] START_VAL = POS_W'(START_POS);

    if (TRACK_LEN < 2 || (2 ** POS_W) < TRACK_LEN) begin : g_bad_geometry
        $error("lemming_world: TRACK_LEN must be >= 2 and fit in POS_W bits");
    end
    if (HOLE_MAP[START_POS] != 1'b0) begin : g_bad_start
        $error("lemming_world: START_POS must not be a hole cell");
    end
    if (STEP_DIV < 1 || FALL_CYCLES < 1) begin : g_bad_timing
        $error("lemming_world: STEP_DIV and FALL_CYCLES must be >= 1");
    end

    logic [POS_W-1:0]        pos_q, pos_d;
    logic [TRACK_LEN-1:0]    hole_q, hole_d;
    logic [FALL_COUNT_W-1:0] fall_count_q, fall_count_d;
    logic                    ground_dly_q;
    logic                    err_q, err_d;

    logic       step_en, step_tc, fall_tc;
    logic [1:0] active_cnt;

    // Every output is derived from registers so the walker loop has no combinational path.
    assign ground       = ~hole_q[pos_q];
    assign bump_left    = ground & (pos_q == '0);
    assign bump_right   = ground & (pos_q == LAST_POS);
    assign pos          = pos_q;
    assign fall_count   = fall_count_q;
    assign protocol_err = err_q;

    assign step_en    = ground & (walk_left ^ walk_right) & ~aaah;
    assign active_cnt = {1'b0, walk_left} + {1'b0, walk_right} + {1'b0, aaah};

    lemming_mod_counter #(.N(STEP_DIV)) u_step_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (step_en),
        .clr_i (~step_en),
        .tc_o  (step_tc)
    );

    lemming_mod_counter #(.N(FALL_CYCLES)) u_fall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (~ground),
        .clr_i (ground),
        .tc_o  (fall_tc)
    );

    always_comb begin
        pos_d        = pos_q;
        hole_d       = hole_q;
        fall_count_d = fall_count_q;
        err_d        = err_q;

        if (step_tc) begin
            if (walk_left && pos_q != '0) begin
                pos_d = pos_q - 1'b1;
            end else if (walk_right && pos_q != LAST_POS) begin
                pos_d = pos_q + 1'b1;
            end
        end

        // Landing fills the hole so the walker never falls twice at the same cell.
        if (fall_tc) begin
            hole_d[pos_q] = 1'b0;
            if (fall_count_q != '1) begin
                fall_count_d = fall_count_q + 1'b1;
            end
        end

        // The walker reacts to ground one cycle late, hence the delayed comparison.
        if (active_cnt != 2'd1 || aaah != ~ground_dly_q) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q        <= START_VAL;
            hole_q       <= HOLE_MAP;
            fall_count_q <= '0;
            ground_dly_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            hole_q       <= hole_d;
            fall_count_q <= fall_count_d;
            ground_dly_q <= ground;
            err_q        <= err_d;
        end
    end

endmodule
